// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory request port between the instruction
// fetch unit and the load/store unit. Only one transaction is in flight at a
// time. Requests use a valid/ready handshake and responses are registered.
// The LSU normally wins contention. A streak counter hands the port to the
// fetch unit after MAX_LS_STREAK consecutive LSU wins, so fetch is never
// locked out.
module mem_port_arbiter #(
  parameter int AW            = 64,
  parameter int DW            = 64,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic            arb_clk_i,
  input  logic            arb_rst_i,

  input  logic            arb_if_req_valid_i,
  output logic            arb_if_req_ready_o,
  input  logic [AW-1:0]   arb_if_addr_i,
  output logic            arb_if_resp_valid_o,
  output logic [DW-1:0]   arb_if_rdata_o,

  input  logic            arb_ls_req_valid_i,
  output logic            arb_ls_req_ready_o,
  input  logic            arb_ls_wen_i,
  input  logic [AW-1:0]   arb_ls_addr_i,
  input  logic [DW-1:0]   arb_ls_wdata_i,
  input  logic [DW/8-1:0] arb_ls_wmask_i,
  output logic            arb_ls_resp_valid_o,
  output logic [DW-1:0]   arb_ls_rdata_o,

  output logic            arb_mem_req_valid_o,
  input  logic            arb_mem_req_ready_i,
  output logic            arb_mem_wen_o,
  output logic [AW-1:0]   arb_mem_addr_o,
  output logic [DW-1:0]   arb_mem_wdata_o,
  output logic [DW/8-1:0] arb_mem_wmask_o,
  input  logic            arb_mem_resp_valid_i,
  input  logic [DW-1:0]   arb_mem_rdata_i
);

  localparam int MW = DW / 8;
  // The streak counter needs at least one bit, even when the guard is disabled.
  localparam int SW = (MAX_LS_STREAK > 0) ? $clog2(MAX_LS_STREAK + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  // Owner encoding: 1 = LSU, 0 = IFU.
  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_LS = 1'b1;

  state_e          state_q, state_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic            owner_q, owner_d;
  logic            req_wen_q, req_wen_d;
  logic [AW-1:0]   req_addr_q, req_addr_d;
  logic [DW-1:0]   req_wdata_q, req_wdata_d;
  logic [MW-1:0]   req_wmask_q, req_wmask_d;
  logic            mem_req_valid_q, mem_req_valid_d;
  logic            if_resp_valid_q, if_resp_valid_d;
  logic            ls_resp_valid_q, ls_resp_valid_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   ls_rdata_q, ls_rdata_d;

  logic            streak_full;
  logic            grant_if;
  logic            grant_ls;

  // Pick a winner while idle. The LSU wins unless the fetch unit has waited
  // through a full streak of LSU grants. Nothing is granted during reset.
  always_comb begin
    streak_full = (MAX_LS_STREAK != 0) && (streak_q == STREAK_MAX);
    grant_if    = 1'b0;
    grant_ls    = 1'b0;
    if ((state_q == IDLE) && !arb_rst_i) begin
      if (arb_ls_req_valid_i && arb_if_req_valid_i) begin
        if (streak_full) begin
          grant_if = 1'b1;
        end else begin
          grant_ls = 1'b1;
        end
      end else if (arb_ls_req_valid_i) begin
        grant_ls = 1'b1;
      end else if (arb_if_req_valid_i) begin
        grant_if = 1'b1;
      end
    end
  end

  // Next-state and datapath computation for the transaction sequencer.
  always_comb begin
    state_d         = state_q;
    streak_d        = streak_q;
    owner_d         = owner_q;
    req_wen_d       = req_wen_q;
    req_addr_d      = req_addr_q;
    req_wdata_d     = req_wdata_q;
    req_wmask_d     = req_wmask_q;
    mem_req_valid_d = mem_req_valid_q;
    if_resp_valid_d = 1'b0;
    ls_resp_valid_d = 1'b0;
    if_rdata_d      = if_rdata_q;
    ls_rdata_d      = ls_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_ls) begin
          owner_d         = OWNER_LS;
          req_wen_d       = arb_ls_wen_i;
          req_addr_d      = arb_ls_addr_i;
          req_wdata_d     = arb_ls_wdata_i;
          // A read never carries byte enables, whatever the LSU drives.
          req_wmask_d     = arb_ls_wen_i ? arb_ls_wmask_i : '0;
          mem_req_valid_d = 1'b1;
          state_d         = REQ;
          if (arb_if_req_valid_i) begin
            if (streak_q != STREAK_MAX) begin
              streak_d = streak_q + 1'b1;
            end
          end else begin
            streak_d = '0;
          end
        end else if (grant_if) begin
          owner_d         = OWNER_IF;
          req_wen_d       = 1'b0;
          req_addr_d      = arb_if_addr_i;
          req_wdata_d     = '0;
          req_wmask_d     = '0;
          mem_req_valid_d = 1'b1;
          state_d         = REQ;
          streak_d        = '0;
        end
      end

      REQ: begin
        if (arb_mem_req_ready_i) begin
          mem_req_valid_d = 1'b0;
          state_d         = WAIT;
        end
      end

      WAIT: begin
        if (arb_mem_resp_valid_i) begin
          if (owner_q == OWNER_LS) begin
            ls_rdata_d      = arb_mem_rdata_i;
            ls_resp_valid_d = 1'b1;
          end else begin
            if_rdata_d      = arb_mem_rdata_i;
            if_resp_valid_d = 1'b1;
          end
          state_d = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset drops any in-flight transaction.
  always_ff @(posedge arb_clk_i) begin
    if (arb_rst_i) begin
      state_q         <= IDLE;
      streak_q        <= '0;
      owner_q         <= OWNER_IF;
      req_wen_q       <= 1'b0;
      req_addr_q      <= '0;
      req_wdata_q     <= '0;
      req_wmask_q     <= '0;
      mem_req_valid_q <= 1'b0;
      if_resp_valid_q <= 1'b0;
      ls_resp_valid_q <= 1'b0;
      if_rdata_q      <= '0;
      ls_rdata_q      <= '0;
    end else begin
      state_q         <= state_d;
      streak_q        <= streak_d;
      owner_q         <= owner_d;
      req_wen_q       <= req_wen_d;
      req_addr_q      <= req_addr_d;
      req_wdata_q     <= req_wdata_d;
      req_wmask_q     <= req_wmask_d;
      mem_req_valid_q <= mem_req_valid_d;
      if_resp_valid_q <= if_resp_valid_d;
      ls_resp_valid_q <= ls_resp_valid_d;
      if_rdata_q      <= if_rdata_d;
      ls_rdata_q      <= ls_rdata_d;
    end
  end

  assign arb_if_req_ready_o  = grant_if;
  assign arb_ls_req_ready_o  = grant_ls;
  assign arb_if_resp_valid_o = if_resp_valid_q;
  assign arb_if_rdata_o      = if_rdata_q;
  assign arb_ls_resp_valid_o = ls_resp_valid_q;
  assign arb_ls_rdata_o      = ls_rdata_q;
  assign arb_mem_req_valid_o = mem_req_valid_q;
  assign arb_mem_wen_o       = req_wen_q;
  assign arb_mem_addr_o      = req_addr_q;
  assign arb_mem_wdata_o     = req_wdata_q;
  assign arb_mem_wmask_o     = req_wmask_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. It drives two instances from the same
// stimulus: one with the default streak guard of 4, and one with the guard
// disabled (pure LSU priority).
module tb_mem_port_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_valid = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          ls_valid = 1'b0;
  logic          ls_wen = 1'b0;
  logic [AW-1:0] ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0;
  logic [MW-1:0] ls_wmask = '0;
  logic          mem_ready = 1'b0;
  logic          mem_resp = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  logic          if_ready, if_resp, ls_ready, ls_resp, mem_valid, mem_wen;
  logic [DW-1:0] if_rdata, ls_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [MW-1:0] mem_wmask;

  logic          if_ready0, if_resp0, ls_ready0, ls_resp0, mem_valid0, mem_wen0;
  logic [DW-1:0] if_rdata0, ls_rdata0, mem_wdata0;
  logic [AW-1:0] mem_addr0;
  logic [MW-1:0] mem_wmask0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_LS_STREAK(4)) dut (
    .arb_clk_i(clk), .arb_rst_i(rst),
    .arb_if_req_valid_i(if_valid), .arb_if_req_ready_o(if_ready),
    .arb_if_addr_i(if_addr), .arb_if_resp_valid_o(if_resp),
    .arb_if_rdata_o(if_rdata),
    .arb_ls_req_valid_i(ls_valid), .arb_ls_req_ready_o(ls_ready),
    .arb_ls_wen_i(ls_wen), .arb_ls_addr_i(ls_addr),
    .arb_ls_wdata_i(ls_wdata), .arb_ls_wmask_i(ls_wmask),
    .arb_ls_resp_valid_o(ls_resp), .arb_ls_rdata_o(ls_rdata),
    .arb_mem_req_valid_o(mem_valid), .arb_mem_req_ready_i(mem_ready),
    .arb_mem_wen_o(mem_wen), .arb_mem_addr_o(mem_addr),
    .arb_mem_wdata_o(mem_wdata), .arb_mem_wmask_o(mem_wmask),
    .arb_mem_resp_valid_i(mem_resp), .arb_mem_rdata_i(mem_rdata)
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_LS_STREAK(0)) dut0 (
    .arb_clk_i(clk), .arb_rst_i(rst),
    .arb_if_req_valid_i(if_valid), .arb_if_req_ready_o(if_ready0),
    .arb_if_addr_i(if_addr), .arb_if_resp_valid_o(if_resp0),
    .arb_if_rdata_o(if_rdata0),
    .arb_ls_req_valid_i(ls_valid), .arb_ls_req_ready_o(ls_ready0),
    .arb_ls_wen_i(ls_wen), .arb_ls_addr_i(ls_addr),
    .arb_ls_wdata_i(ls_wdata), .arb_ls_wmask_i(ls_wmask),
    .arb_ls_resp_valid_o(ls_resp0), .arb_ls_rdata_o(ls_rdata0),
    .arb_mem_req_valid_o(mem_valid0), .arb_mem_req_ready_i(mem_ready),
    .arb_mem_wen_o(mem_wen0), .arb_mem_addr_o(mem_addr0),
    .arb_mem_wdata_o(mem_wdata0), .arb_mem_wmask_o(mem_wmask0),
    .arb_mem_resp_valid_i(mem_resp), .arb_mem_rdata_i(mem_rdata)
  );

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Run one full reset sequence: two cycles high, then release.
  task automatic doReset();
    rst = 1'b1;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
  endtask

  // Main directed sequence.
  initial begin
    byte   g4[$];
    int    if0_cnt;
    int    ls0_cnt;
    string exp4;

    // Reset state.
    doReset();
    applyStimulus();
    #1;
    checkOutput("rst_if_ready", 64'(if_ready), 64'h0);
    checkOutput("rst_ls_ready", 64'(ls_ready), 64'h0);
    checkOutput("rst_mem_valid", 64'(mem_valid), 64'h0);
    checkOutput("rst_if_resp", 64'(if_resp), 64'h0);
    checkOutput("rst_ls_resp", 64'(ls_resp), 64'h0);
    checkOutput("rst_mem_addr", mem_addr, 64'h0);
    checkOutput("rst_if_rdata", if_rdata, 64'h0);

    // Lone fetch, memory ready immediately, response two cycles after handshake.
    applyStimulus();
    if_valid  = 1'b1;
    if_addr   = 64'h8000_0000;
    mem_ready = 1'b1;
    #1;
    checkOutput("fetch_if_ready", 64'(if_ready), 64'h1);
    checkOutput("fetch_ls_ready", 64'(ls_ready), 64'h0);
    applyStimulus();
    if_valid = 1'b0;
    if_addr  = 64'hdead_beef;
    checkOutput("fetch_mem_valid", 64'(mem_valid), 64'h1);
    checkOutput("fetch_mem_addr", mem_addr, 64'h8000_0000);
    checkOutput("fetch_mem_wen", 64'(mem_wen), 64'h0);
    checkOutput("fetch_mem_wmask", 64'(mem_wmask), 64'h0);
    checkOutput("fetch_if_ready_busy", 64'(if_ready), 64'h0);
    applyStimulus();
    mem_ready = 1'b0;
    mem_resp  = 1'b1;
    mem_rdata = 64'h13;
    checkOutput("fetch_mem_valid_drop", 64'(mem_valid), 64'h0);
    checkOutput("fetch_if_resp_early", 64'(if_resp), 64'h0);
    applyStimulus();
    mem_resp  = 1'b0;
    mem_rdata = 64'h0;
    checkOutput("fetch_if_resp", 64'(if_resp), 64'h1);
    checkOutput("fetch_if_rdata", if_rdata, 64'h13);
    checkOutput("fetch_ls_resp", 64'(ls_resp), 64'h0);
    applyStimulus();
    checkOutput("fetch_if_resp_pulse", 64'(if_resp), 64'h0);
    checkOutput("fetch_if_rdata_hold", if_rdata, 64'h13);

    // LSU write with memory backpressure. A stray response during REQ is ignored.
    ls_valid = 1'b1;
    ls_wen   = 1'b1;
    ls_addr  = 64'h8000_1000;
    ls_wdata = 64'h1122_3344_5566_7788;
    ls_wmask = 8'h0F;
    #1;
    checkOutput("wr_ls_ready", 64'(ls_ready), 64'h1);
    applyStimulus();
    ls_valid = 1'b0;
    ls_addr  = 64'h0;
    ls_wdata = 64'h0;
    ls_wmask = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      mem_resp  = (k == 1);
      mem_rdata = (k == 1) ? 64'hdead : 64'h0;
      mem_ready = (k == 3);
      checkOutput($sformatf("wr_mem_valid_%0d", k), 64'(mem_valid), 64'h1);
      checkOutput($sformatf("wr_mem_addr_%0d", k), mem_addr, 64'h8000_1000);
      checkOutput($sformatf("wr_mem_wdata_%0d", k), mem_wdata, 64'h1122_3344_5566_7788);
      checkOutput($sformatf("wr_mem_wmask_%0d", k), 64'(mem_wmask), 64'h0F);
      checkOutput($sformatf("wr_mem_wen_%0d", k), 64'(mem_wen), 64'h1);
      applyStimulus();
      checkOutput($sformatf("wr_ls_resp_early_%0d", k), 64'(ls_resp), 64'h0);
    end
    mem_ready = 1'b0;
    mem_resp  = 1'b1;
    mem_rdata = 64'h55;
    checkOutput("wr_mem_valid_drop", 64'(mem_valid), 64'h0);
    applyStimulus();
    mem_resp  = 1'b0;
    mem_rdata = 64'h0;
    checkOutput("wr_ls_resp", 64'(ls_resp), 64'h1);
    checkOutput("wr_ls_rdata", ls_rdata, 64'h55);
    checkOutput("wr_if_resp", 64'(if_resp), 64'h0);
    checkOutput("wr_if_rdata_hold", if_rdata, 64'h13);
    applyStimulus();
    checkOutput("wr_ls_resp_pulse", 64'(ls_resp), 64'h0);

    // Reset while waiting for the memory response, then a late response.
    if_valid  = 1'b1;
    if_addr   = 64'h100;
    mem_ready = 1'b1;
    applyStimulus();
    if_valid = 1'b0;
    applyStimulus();
    mem_ready = 1'b0;
    rst       = 1'b1;
    applyStimulus();
    rst       = 1'b0;
    mem_resp  = 1'b1;
    mem_rdata = 64'hbad;
    applyStimulus();
    mem_resp  = 1'b0;
    mem_rdata = 64'h0;
    checkOutput("abort_if_resp", 64'(if_resp), 64'h0);
    checkOutput("abort_ls_resp", 64'(ls_resp), 64'h0);
    checkOutput("abort_if_rdata", if_rdata, 64'h0);
    checkOutput("abort_mem_valid", 64'(mem_valid), 64'h0);
    applyStimulus();
    checkOutput("abort_if_resp_late", 64'(if_resp), 64'h0);
    if_valid = 1'b1;
    if_addr  = 64'h200;
    #1;
    checkOutput("abort_next_if_ready", 64'(if_ready), 64'h1);
    applyStimulus();
    if_valid  = 1'b0;
    mem_ready = 1'b1;
    checkOutput("abort_next_mem_addr", mem_addr, 64'h200);
    applyStimulus();
    mem_ready = 1'b0;
    mem_resp  = 1'b1;
    mem_rdata = 64'h77;
    applyStimulus();
    mem_resp = 1'b0;
    checkOutput("abort_next_if_resp", 64'(if_resp), 64'h1);
    checkOutput("abort_next_if_rdata", if_rdata, 64'h77);

    // Continuous contention on both instances. Memory always ready and responding.
    doReset();
    if_valid  = 1'b1;
    ls_valid  = 1'b1;
    ls_wen    = 1'b0;
    ls_addr   = 64'h40;
    mem_ready = 1'b1;
    mem_resp  = 1'b1;
    mem_rdata = 64'h1;
    if0_cnt   = 0;
    ls0_cnt   = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (ls_ready) g4.push_back("L");
      if (if_ready) g4.push_back("I");
      if (ls_ready0) ls0_cnt++;
      if (if_ready0) if0_cnt++;
      applyStimulus();
    end
    if_valid  = 1'b0;
    ls_valid  = 1'b0;
    mem_ready = 1'b0;
    mem_resp  = 1'b0;
    exp4 = "LLLLILLLLI";
    checkOutput("streak4_grant_count", 64'(g4.size()), 64'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < g4.size()) begin
        checkOutput($sformatf("streak4_grant_%0d", i), 64'(g4[i]), 64'(exp4[i]));
      end
    end
    checkOutput("streak0_if_grants", 64'(if0_cnt), 64'd0);
    checkOutput("streak0_ls_grants", 64'(ls0_cnt), 64'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single core memory port between instruction fetch (IFU) and load/store (LSU) requesters.
- Sits between IFU/LSU and the memory-side path (crossbar/SRAM bridge) once fetch and data access move onto a shared multi-cycle bus.
- One outstanding transaction at a time, valid/ready request handshakes, registered responses.
- LSU has priority, with a starvation guard so fetch is never locked out.

Parameters:
- AW, 64, address width.
- DW, 64, data width; must be a multiple of 8.
- MAX_LS_STREAK, 4, max consecutive LSU grants while IFU waits; 0 = pure LSU priority.

Ports:
- arb_clk_i  in  1  clock; all logic on rising edge.
- arb_rst_i  in  1  reset, synchronous, active-high.
- arb_if_req_valid_i  in  1  IFU fetch request.
- arb_if_req_ready_o  out  1  IFU request accepted this cycle.
- arb_if_addr_i  in  AW  fetch address.
- arb_if_resp_valid_o  out  1  fetch data valid, one-cycle pulse.
- arb_if_rdata_o  out  DW  fetch data.
- arb_ls_req_valid_i  in  1  LSU request.
- arb_ls_req_ready_o  out  1  LSU request accepted.
- arb_ls_wen_i  in  1  1 = write, 0 = read.
- arb_ls_addr_i  in  AW  data address.
- arb_ls_wdata_i  in  DW  write data.
- arb_ls_wmask_i  in  DW/8  byte write mask.
- arb_ls_resp_valid_o  out  1  read data / write ack, one-cycle pulse.
- arb_ls_rdata_o  out  DW  read data.
- arb_mem_req_valid_o  out  1  request to memory.
- arb_mem_req_ready_i  in  1  memory accepts request.
- arb_mem_wen_o  out  1  write enable.
- arb_mem_addr_o  out  AW  address.
- arb_mem_wdata_o  out  DW  write data.
- arb_mem_wmask_o  out  DW/8  byte mask; all-zero for reads.
- arb_mem_resp_valid_i  in  1  memory response (read data or write ack).
- arb_mem_rdata_i  in  DW  memory read data.

Behaviour:
- Reset:
  - All outputs 0.
  - State IDLE, streak counter 0, owner register 0.
  - Asserting reset in any state aborts the in-flight transaction; no response pulse is issued for it.
- States: IDLE, REQ, WAIT, RESP.
- Grant, evaluated combinationally in IDLE only:
  - Only one requester valid: grant it.
  - Both valid: grant LSU, unless MAX_LS_STREAK != 0 and streak == MAX_LS_STREAK, in which case grant IFU.
- Ready:
  - arb_*_req_ready_o is high only in IDLE and only for the granted requester.
  - It never asserts outside IDLE.
- IDLE:
  - On handshake, capture addr, wen, wdata and wmask into request registers. IFU requests force wen = 0 and wmask = 0.
  - Record the owner, then go to REQ.
- REQ:
  - arb_mem_req_valid_o = 1 and mem outputs come from the request registers, held stable until arb_mem_req_ready_i.
  - On ready, go to WAIT.
- WAIT:
  - On arb_mem_resp_valid_i, register arb_mem_rdata_i into the owner's rdata output, then go to RESP.
  - arb_mem_resp_valid_i is ignored in IDLE, REQ and RESP.
- RESP:
  - The owner's resp_valid_o is high for exactly one cycle, then back to IDLE.
  - The other requester's resp_valid_o stays 0.
- Rdata outputs hold their last value until the next response to the same owner.
- Latency:
  - Handshake at cycle T gives mem_req_valid at T+1.
  - With ready at T+1 and response at T+2, resp_valid is at T+3.
  - Next grant is possible at T+4. Minimum 4 cycles per transaction.
- Streak counter (width clog2(MAX_LS_STREAK+1), saturating):
  - Increments on an LSU grant while arb_if_req_valid_i = 1.
  - Clears on any IFU grant, and on an LSU grant with the IFU not requesting.
- Requester valid dropped before grant: no effect, no capture.

Test Plan:
- Reset check: arb_rst_i high 2 cycles, then release, no requests → all outputs 0, state IDLE; arb_if_req_ready_o low with no request.
- Lone fetch: IFU valid, addr 0x8000_0000; mem ready immediate; resp 2 cycles later with rdata 0x0000_0013 → arb_mem_wen_o=0, arb_mem_wmask_o=0x00; arb_if_resp_valid_o pulses once with 0x13; arb_ls_resp_valid_o stays 0.
- LSU write under backpressure: addr 0x8000_1000, wdata 0x1122334455667788, wmask 0x0F; mem_req_ready held low 3 cycles → mem outputs stable all 4 cycles; single ls resp pulse after ack.
- Contention, MAX_LS_STREAK=4: IFU and LSU valid continuously → grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF.
- Contention, MAX_LS_STREAK=0: same stimulus → IFU never granted while LSU valid.
- Reset mid-transaction: assert reset in WAIT, then a late arb_mem_resp_valid_i arrives → no resp pulse on either side; the next IFU request is accepted normally from IDLE.
